encoder16to4_seq: RTL and testbench
===================================

ENCODER16TO4_SEQ -- requirements
Module: encoder16to4_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 16 request lines and a 4-bit index.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  req is presented for capture.
REQ-005 in_ready  output  1  block can capture a new vector.
REQ-006 req  input  16  multi-hot request vector; bit i means line i is active.
REQ-007 out_valid  output  1  addr is valid.
REQ-008 out_ready  input  1  consumer accepts addr this cycle.
REQ-009 addr  output  4  encoded index of the current active line.
REQ-010 last  output  1  addr is the final index of the captured vector.
REQ-011 cnt  output  5  number of set bits in the captured vector, range 0..16.

Function
REQ-012 The block SHALL implement two states: IDLE and EMIT.
REQ-013 in_ready SHALL be 1 exactly when the state is IDLE.
REQ-014 Capture in IDLE occurs when in_valid=1; the block SHALL latch req into a 16-bit pending register and latch popcount(req) into cnt.
REQ-015 After a capture with req!=0, the state SHALL become EMIT, and out_valid SHALL be 1 on the next cycle (one-cycle latency).
REQ-016 A capture with req=0 SHALL set cnt=0, keep the state at IDLE, and never assert out_valid.
REQ-017 In EMIT, out_valid SHALL be 1 and addr SHALL be the selected set bit of pending: the lowest index by default (see REQ-027).
REQ-018 last SHALL be 1 exactly when pending has one bit set; last is qualified by out_valid and is 0 in IDLE.
REQ-019 Handshake: when out_valid=1 and out_ready=1, the block SHALL clear the addressed bit in pending; if last=1, the state SHALL return to IDLE on the same edge.
REQ-020 When out_ready=0, addr, last and out_valid SHALL hold stable; no bit is cleared.
REQ-021 Back-to-back operation: indices SHALL issue one per cycle while out_ready=1.
REQ-022 in_ready=1 SHALL appear on the cycle after the last handshake, so a new capture takes at least 1 idle cycle between vectors.
REQ-023 Changes to req or in_valid during EMIT SHALL have no effect.
REQ-024 cnt SHALL hold its captured value until the next capture; it does not decrement.

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) force the following, including mid-EMIT, where pending indices are discarded and never emitted:
- state=IDLE
- pending=0
- out_valid=0
- addr=0
- last=0
- cnt=0
- in_ready=1
REQ-026 After rst_n deasserts, the first capture SHALL be possible on the first rising edge.

Configuration
REQ-027 The macro ENC_MSB_FIRST_EN controls emission order:
- Defined: addr SHALL select the highest set index of pending (descending order).
- Undefined: addr SHALL select the lowest set index (ascending order).
- All other behaviour SHALL be identical in both builds.

Verification
REQ-028 Reset sequence: assert rst_n=0 mid-EMIT with req=16'h00F0 captured -> out_valid=0, in_ready=1, cnt=0 immediately; no further addr is issued after release.
REQ-029 Capture req=16'h8421 with out_ready=1 constantly -> addr sequence 0,5,10,15 (15,10,5,0 with ENC_MSB_FIRST_EN) on consecutive cycles; last=1 only on the 4th; cnt=4.
REQ-030 Capture req=16'h0001 -> single addr=0 with last=1; cnt=1; in_ready=1 on the cycle after the handshake.
REQ-031 Capture req=16'hFFFF with out_ready toggling 1,0 -> 16 indices, each held stable across stall cycles; cnt=16; last only on the 16th.
REQ-032 Capture req=16'h0000 -> cnt=0, out_valid stays 0, in_ready stays 1.
REQ-033 During EMIT of 16'h0300, drive in_valid=1 with req=16'h0001 -> only indices 8,9 are emitted, and the new vector is not captured.

Source files
------------

// File: rtl/encoder16to4_seq.sv
// encoder16to4_seq: captures a 16-bit multi-hot request vector and emits the
// index of each set bit, one per handshake, with a popcount of the vector.
// Optional macro ENC_MSB_FIRST_EN: emit indices highest-first instead of
// lowest-first.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | ready to capture; out_valid low, in_ready high
//   S_EMIT | pending has bits left; addr/last presented with out_valid
module encoder16to4_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  addr,
  output logic        last,
  output logic [4:0]  cnt
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t      state;
  logic [15:0] pending;
  logic [15:0] pending_nxt;

  function automatic logic [3:0] sel_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
`ifdef ENC_MSB_FIRST_EN
    // later (higher) hits overwrite earlier ones: highest set index wins
    for (int i = 0; i < 16; i++)
      if (v[i]) idx = i[3:0];
`else
    // scan downwards so the lowest set index wins
    for (int i = 15; i >= 0; i--)
      if (v[i]) idx = i[3:0];
`endif
    return idx;
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++)
      n = n + {4'd0, v[i]};
    return n;
  endfunction

  function automatic logic is_single(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

  // vector left over once the currently presented index is accepted
  assign pending_nxt = pending & ~(16'd1 << addr);

  // capture is only possible in IDLE, so in_ready follows the state register
  assign in_ready = (state == S_IDLE);

  // FSM with registered addr/last/out_valid so outputs are glitch-free and
  // naturally hold during stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pending   <= '0;
      out_valid <= 1'b0;
      addr      <= '0;
      last      <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            cnt <= popcount(req);
            // an empty vector only updates cnt; there is nothing to emit
            if (req != 16'd0) begin
              pending   <= req;
              addr      <= sel_idx(req);
              last      <= is_single(req);
              out_valid <= 1'b1;
              state     <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (last) begin
              pending   <= '0;
              addr      <= '0;
              last      <= 1'b0;
              out_valid <= 1'b0;
              state     <= S_IDLE;
            end else begin
              pending <= pending_nxt;
              addr    <= sel_idx(pending_nxt);
              last    <= is_single(pending_nxt);
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          pending   <= '0;
          out_valid <= 1'b0;
          addr      <= '0;
          last      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder16to4_seq.sv
// Testbench for encoder16to4_seq: scoreboard of expected {last, addr} pairs,
// pushed at capture and popped on each output handshake.
module tb_encoder16to4_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] req;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  addr;
  logic        last;
  logic [4:0]  cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] exp_q[$];
  bit         rdy_tog;
  bit         held;
  logic [3:0] held_addr;
  logic       held_last;

  encoder16to4_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req       (req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .addr      (addr),
    .last      (last),
    .cnt       (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected emission order for a vector, independent of the RTL encoder
  task automatic push_expected(input logic [15:0] v);
    int n;
    int k;
    n = $countones(v);
    k = 0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 15; i >= 0; i--) begin
`else
    for (int i = 0; i < 16; i++) begin
`endif
      if (v[i]) begin
        k++;
        exp_q.push_back({(k == n), i[3:0]});
      end
    end
  endtask

  // out_ready: constant 1, or alternating 1,0 when rdy_tog is set
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_tog) out_ready = ~out_ready;
      else         out_ready = 1'b1;
    end
  end

  // monitor: pop on handshake, check stall stability, flag spurious valid
  always @(negedge clk) begin
    logic [4:0] e;
    if (exp_q.size() == 0) begin
      check_val("no_spurious_valid", out_valid, 0);
    end
    if (held && out_valid) begin
      check_val("stall_addr_hold", addr, held_addr);
      check_val("stall_last_hold", last, held_last);
    end
    held = 1'b0;
    if (out_valid && out_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("emit_addr", addr, e[3:0]);
      check_val("emit_last", last, e[4]);
    end else if (out_valid && !out_ready) begin
      held      = 1'b1;
      held_addr = addr;
      held_last = last;
    end
  end

  task automatic run_vec(input logic [15:0] v, input bit tog, input bit noise);
    int pc;
    int cycles;
    pc = $countones(v);
    check_val("pre_in_ready", in_ready, 1);
    push_expected(v);
    rdy_tog  = tog;
    req      = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (noise) req = 16'h0001;
    else begin
      in_valid = 1'b0;
      req      = 16'($urandom);
    end
    check_val("cap_cnt", cnt, pc);
    check_val("cap_out_valid", out_valid, (v != 16'd0));
    check_val("cap_in_ready", in_ready, (v == 16'd0));
    cycles = 0;
    while (!in_ready && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    in_valid = 1'b0;
    check_val("drain_in_ready", in_ready, 1);
    if (!tog) check_val("drain_cycles", cycles, pc);
    check_val("drain_queue_empty", exp_q.size(), 0);
    check_val("cnt_hold", cnt, pc);
    rdy_tog = 1'b0;
    @(posedge clk);
    #1;
    check_val("idle_out_valid", out_valid, 0);
    check_val("idle_cnt", cnt, pc);
  endtask

  initial begin
    logic [15:0] rv;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    req      = '0;
    rdy_tog  = 1'b0;
    held     = 1'b0;
    #2;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_cnt", cnt, 0);
    check_val("rst_addr", addr, 0);
    check_val("rst_last", last, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // first capture on the first rising edge after reset release
    run_vec(16'h8421, 1'b0, 1'b0);
    run_vec(16'h0001, 1'b0, 1'b0);
    run_vec(16'hFFFF, 1'b1, 1'b0);
    run_vec(16'h0000, 1'b0, 1'b0);
    run_vec(16'h0300, 1'b0, 1'b1);
    run_vec(16'h8000, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rv = 16'($urandom);
      run_vec(rv, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    // asynchronous reset in the middle of emitting 16'h00F0
    push_expected(16'h00F0);
    req      = 16'h00F0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check_val("mid_emit_valid", out_valid, 1);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check_val("async_rst_out_valid", out_valid, 0);
    check_val("async_rst_in_ready", in_ready, 1);
    check_val("async_rst_cnt", cnt, 0);
    check_val("async_rst_addr", addr, 0);
    check_val("async_rst_last", last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_val("post_rst_out_valid", out_valid, 0);
    check_val("post_rst_in_ready", in_ready, 1);
    run_vec(16'h0001, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
